// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump
//
// Walks register indices 0..LAST_ADDR of an external, asynchronously read
// register file and streams each word out over a valid/ready port, one word
// every two cycles when the consumer is always ready.
//
// Optional feature (macro REG_DUMP_CHECKSUM_EN):
//   When defined, an XOR checksum of every dumped word is appended as an extra
//   word with out_idx = 32 and out_last = 1. The word at LAST_ADDR then carries
//   out_last = 0. When undefined there is no checksum logic at all.
//
// Parameters:
//   LAST_ADDR  highest register index dumped (0..31)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   start      request a dump (ignored while busy)
//   busy       high whenever the FSM is not IDLE
//   rd_addr    register-file read address (= idx[4:0] in all states)
//   rd_data    register-file read data for rd_addr
//   out_valid  out_data / out_idx / out_last are valid
//   out_ready  consumer accepts the word when out_valid is also high
//   out_data   dumped word
//   out_idx    register index of out_data (32 = checksum word)
//   out_last   final word of the dump
//   done       one-cycle pulse after the final word is accepted
//   dbg_state  current FSM state (IDLE=0, LOAD=1, SEND=2)
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high; while out_valid is high and out_ready is low, out_data,
// out_idx and out_last hold stable, and out_valid never drops without a
// transfer (except on reset).
// -----------------------------------------------------------------------------
module reg_dump #(
    parameter int LAST_ADDR = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(LAST_ADDR);

`ifdef REG_DUMP_CHECKSUM_EN
    // The checksum word is loaded on the index following LAST_ADDR.
    localparam logic [5:0] CSUM_IDX = LAST_IDX + 6'd1;
    logic [31:0] r_csum;
`endif

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [31:0] r_data;
    logic [5:0]  r_out_idx;
    logic        r_valid;
    logic        r_last;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 6'd0;
            r_data    <= 32'd0;
            r_out_idx <= 6'd0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_csum    <= 32'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_idx   <= 6'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                        r_csum  <= 32'd0;
`endif
                    end
                end

                S_LOAD: begin
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
`ifdef REG_DUMP_CHECKSUM_EN
                    if (r_idx == CSUM_IDX) begin
                        r_data    <= r_csum;
                        r_out_idx <= 6'd32;
                        r_last    <= 1'b1;
                    end else begin
                        r_data    <= rd_data;
                        r_out_idx <= r_idx;
                        r_last    <= 1'b0;
                        r_csum    <= r_csum ^ rd_data;
                    end
`else
                    r_data    <= rd_data;
                    r_out_idx <= r_idx;
                    r_last    <= (r_idx == LAST_IDX);
`endif
                end

                S_SEND: begin
                    if (r_valid && out_ready) begin
                        r_valid <= 1'b0;
                        if (r_last) begin
                            // Final word accepted: done pulses in the first
                            // IDLE cycle, where a new start is already legal.
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_last  <= 1'b0;
                            r_idx   <= 6'd0;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign rd_addr   = r_idx[4:0];
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_last;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: full 32-register dump
  logic        start_a, busy_a, out_valid_a, out_ready_a, out_last_a, done_a;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a, out_data_a;
  logic [5:0]  out_idx_a;
  logic [1:0]  dbg_a;
  logic [31:0] regs_a [32];
  assign rd_data_a = regs_a[rd_addr_a];

  // Instance B: single-register dump
  logic        start_b, busy_b, out_valid_b, out_ready_b, out_last_b, done_b;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b, out_data_b;
  logic [5:0]  out_idx_b;
  logic [1:0]  dbg_b;
  logic [31:0] regs_b [32];
  assign rd_data_b = regs_b[rd_addr_b];

  reg_dump #(.LAST_ADDR(31)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a),
    .done(done_a), .dbg_state(dbg_a)
  );

  reg_dump #(.LAST_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b),
    .done(done_b), .dbg_state(dbg_b)
  );

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: the words still expected from the current dump, in order.
  logic [31:0] exp_q      [$];
  logic [5:0]  exp_idx_q  [$];
  logic        exp_last_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: the dump is simply registers 0..la in order, optionally
  // followed by the XOR of all of them. Words before 'first' were already
  // transferred and are not re-queued.
  function automatic void build_expected(input logic [31:0] rf [32], input int first, input int la);
    logic [31:0] x;
    x = 32'd0;
    exp_q.delete();
    exp_idx_q.delete();
    exp_last_q.delete();
    for (int k = 0; k <= la; k++) begin
      x ^= rf[k];
      if (k >= first) begin
        exp_q.push_back(rf[k]);
        exp_idx_q.push_back(6'(k));
        exp_last_q.push_back(!CSUM && (k == la));
      end
    end
    if (CSUM) begin
      exp_q.push_back(x);
      exp_idx_q.push_back(6'd32);
      exp_last_q.push_back(1'b1);
    end
  endfunction

  // One dump on instance A. Negative indices disable the corresponding event.
  task automatic dump_a(input int ready_mode, input int stall_idx, input int stall_len,
                        input int poke_idx, input int rst_idx, input int wr_idx,
                        input bit pre_started, input bit restart_at_done, input int exp_cycles);
    int cyc;
    int stalled;
    bit poked;
    bit got_done;
    build_expected(regs_a, 0, 31);
    if (!pre_started) begin
      @(negedge clk);
      start_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_after_start", busy_a, 1'b1);
    cyc = 0; stalled = 0; poked = 0; got_done = 0;
    while (cyc < 400 && !got_done) begin
      @(negedge clk);
      cyc++;
      start_a = 1'b0;
      if (done_a) begin
        got_done = 1'b1;
        chk("words_left_at_done", exp_q.size(), 0);
        if (exp_cycles >= 0) chk("start_to_done_cycles", cyc, exp_cycles);
        if (restart_at_done) start_a = 1'b1;
      end else if (out_valid_a) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_extra_word", out_idx_a, 6'h3f);
          break;
        end
        chk("word_data", out_data_a, exp_q[0]);
        chk("word_idx", out_idx_a, exp_idx_q[0]);
        chk("word_last", out_last_a, exp_last_q[0]);
        if (int'(out_idx_a) == rst_idx) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("rst_mid_valid", out_valid_a, 1'b0);
          chk("rst_mid_busy", busy_a, 1'b0);
          chk("rst_mid_idx", out_idx_a, 6'd0);
          chk("rst_mid_data", out_data_a, 32'd0);
          for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_done", done_a, 1'b0);
            @(negedge clk);
          end
          return;
        end
        if (int'(out_idx_a) == poke_idx && !poked) begin
          start_a = 1'b1;
          poked = 1'b1;
        end
        if (int'(out_idx_a) == stall_idx && stalled < stall_len) begin
          out_ready_a = 1'b0;
          stalled++;
        end else if (ready_mode == 1) begin
          out_ready_a = 1'($urandom_range(0, 1));
        end else begin
          out_ready_a = 1'b1;
        end
        if (out_ready_a) begin
          void'(exp_q.pop_front());
          void'(exp_idx_q.pop_front());
          void'(exp_last_q.pop_front());
          if (int'(out_idx_a) == wr_idx) begin
            // Register 20 is not loaded yet, so the new value must appear.
            regs_a[20] = $urandom;
            build_expected(regs_a, wr_idx + 1, 31);
          end
        end
      end else begin
        out_ready_a = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!got_done) begin
      chk("done_timeout", got_done, 1'b1);
    end else if (!restart_at_done) begin
      @(negedge clk);
      chk("done_one_cycle", done_a, 1'b0);
      chk("idle_after_done", busy_a, 1'b0);
    end
  endtask

  task automatic dump_b();
    int cyc;
    bit got_done;
    int nwords;
    build_expected(regs_b, 0, 0);
    nwords = exp_q.size();
    @(negedge clk);
    start_b = 1'b1;
    out_ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0; got_done = 0;
    while (cyc < 50 && !got_done) begin
      @(negedge clk);
      cyc++;
      if (done_b) begin
        got_done = 1'b1;
        chk("b_words_left", exp_q.size(), 0);
        chk("b_cycles", cyc, 2 * nwords);
      end else if (out_valid_b) begin
        if (exp_q.size() == 0) begin
          chk("b_extra_word", out_idx_b, 6'h3f);
          break;
        end
        chk("b_data", out_data_b, exp_q[0]);
        chk("b_idx", out_idx_b, exp_idx_q[0]);
        chk("b_last", out_last_b, exp_last_q[0]);
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
        void'(exp_last_q.pop_front());
      end
    end
    if (!got_done) chk("b_done_timeout", got_done, 1'b1);
    @(negedge clk);
    chk("b_done_one_cycle", done_b, 1'b0);
  endtask

  int w;

  initial begin
    w = CSUM ? 33 : 32;
    rst = 1'b1;
    start_a = 1'b0; out_ready_a = 1'b0;
    start_b = 1'b0; out_ready_b = 1'b0;
    for (int k = 0; k < 32; k++) begin
      regs_a[k] = 32'h1000 + 32'(k);
      regs_b[k] = $urandom;
    end
    regs_b[0] = 32'd0;
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valid", out_valid_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_data", out_data_a, 32'd0);
    chk("rst_idx", out_idx_a, 6'd0);
    chk("rst_last", out_last_a, 1'b0);
    chk("rst_b_busy", busy_b, 1'b0);
    start_a = 1'b0;
    rst = 1'b0;

    // Basic dump, always ready
    dump_a(0, -1, 0, -1, -1, -1, 1'b0, 1'b0, 2 * w);
    // Back-pressure on word 3
    dump_a(0, 3, 5, -1, -1, -1, 1'b0, 1'b0, 2 * w + 5);
    // Reset during word 10, then a clean dump
    dump_a(0, -1, 0, -1, 10, -1, 1'b0, 1'b0, -1);
    dump_a(0, -1, 0, -1, -1, -1, 1'b0, 1'b0, 2 * w);
    // start pulsed while busy
    dump_a(0, -1, 0, 5, -1, -1, 1'b0, 1'b0, 2 * w);

    // register k = k, then register 1 = all ones; restart from the done cycle
    for (int k = 0; k < 32; k++) regs_a[k] = 32'(k);
    dump_a(0, -1, 0, -1, -1, -1, 1'b0, 1'b0, 2 * w);
    regs_a[1] = 32'hFFFF_FFFF;
    dump_a(0, -1, 0, -1, -1, -1, 1'b0, 1'b1, 2 * w);
    dump_a(0, -1, 0, -1, -1, -1, 1'b1, 1'b0, 2 * w);

    // Random contents, random ready, register write during the dump
    for (int k = 0; k < 32; k++) regs_a[k] = $urandom;
    dump_a(1, -1, 0, -1, -1, 5, 1'b0, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 32; k++) regs_a[k] = $urandom;
      dump_a(1, -1, 0, -1, -1, -1, 1'b0, 1'b0, -1);
    end

    // Single-register dump
    dump_b();
    regs_b[0] = $urandom;
    dump_b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 31: highest register index dumped (range 0..31).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a dump of registers 0..LAST_ADDR.
REQ-005 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-006 SHALL have port rd_addr  output  5  register-file read address.
REQ-007 SHALL have port rd_data  input  32  register-file asynchronous read data for rd_addr.
REQ-008 SHALL have port out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the word when out_valid is also high.
REQ-010 SHALL have port out_data  output  32  dumped word.
REQ-011 SHALL have port out_idx  output  6  register index of out_data (32 = checksum word).
REQ-012 SHALL have port out_last  output  1  marks the final word of the dump.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SEND.
REQ-015 IDLE: start=1 -> LOAD with idx=0; start=0 -> stay.
REQ-016 LOAD (one cycle): drive rd_addr=idx; register rd_data into out_data, idx into out_idx; set out_valid=1; -> SEND.
REQ-017 SEND: out_valid=1 and out_ready=0 -> hold out_data, out_idx and out_last stable; out_valid=1 and out_ready=1 -> handshake.
REQ-018 Handshake on a non-final word -> idx+1, LOAD, out_valid=0 for that LOAD cycle.
REQ-019 Handshake on the final word -> IDLE, out_valid=0, done=1 in the next cycle only.
REQ-020 Throughput: one word per 2 cycles when out_ready is held high; first word valid 2 cycles after start is sampled.
REQ-021 start SHALL be ignored while busy=1; start sampled in the done cycle SHALL begin a new dump.
REQ-022 rd_addr SHALL equal idx[4:0] in all states; its value outside LOAD is don't-care to consumers.
REQ-023 Values SHALL reflect rd_data during each word's LOAD cycle; register writes during a dump affect only words not yet loaded.
REQ-024 LAST_ADDR=0: the dump SHALL be a single word, register 0 with out_last=1.

Reset
REQ-025 rst=1 SHALL force IDLE, idx=0, out_valid=0, out_last=0, done=0, out_data=0, out_idx=0, busy=0 at the next edge, overriding start and handshakes.
REQ-026 rst asserted mid-dump SHALL abandon the dump with no done pulse; the next start restarts from index 0.

Configuration
REQ-027 Macro REG_DUMP_CHECKSUM_EN SHALL select the checksum feature.
REQ-028 Macro defined: accumulate the XOR of all dumped words (cleared when start is accepted); after word LAST_ADDR append one extra word with out_data=XOR, out_idx=32, out_last=1, using the same LOAD/SEND timing; the word at LAST_ADDR has out_last=0.
REQ-029 Macro undefined: no checksum logic; the word at LAST_ADDR carries out_last=1; out_idx never exceeds 31.

Verification
REQ-030 Register k preloaded with 0x1000+k, start pulse, out_ready=1 -> 32 words 0x1000..0x101F, idx 0..31, out_last on idx 31, done 1 cycle after, 64 cycles from start to done.
REQ-031 out_ready low for 5 cycles during word 3 -> out_data=0x1003 and idx=3 held stable; no word lost or duplicated.
REQ-032 rst raised during word 10 -> out_valid=0, busy=0, no done; new start -> first word idx 0.
REQ-033 start pulsed while busy at word 5 -> ignored; exactly one dump of 32 words.
REQ-034 REG_DUMP_CHECKSUM_EN defined, register k = k -> 33 words, last word idx 32 data 0x00000000 with out_last=1; with register 1 = 0xFFFFFFFF (others k) -> checksum 0xFFFFFFFE.
REQ-035 LAST_ADDR=0, register 0=0 -> one word 0x00000000, out_last=1, done pulse.
